// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle 32-bit shifter, one bit position per clock.
// Parallel load on start, four shift modes, abort, busy/done handshake.
module seq_shifter (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] din,
  input  logic [4:0]  shamt,
  input  logic [1:0]  mode,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_SRL = 2'b01;
  localparam logic [1:0] M_SRA = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  state_t      state;
  logic [4:0]  cnt;
  logic [1:0]  mode_q;
  logic [31:0] step;

  // single-bit move of the working register for the captured mode
  always_comb begin
    step = result;
    unique case (mode_q)
      M_SLL: step = {result[30:0], 1'b0};
      M_SRL: step = {1'b0, result[31:1]};
      M_SRA: step = {result[31], result[31:1]};
      M_ROR: step = {result[0], result[31:1]};
      default: step = result;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      result <= '0;
      cnt    <= '0;
      mode_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            result <= din;
            cnt    <= shamt;
            mode_q <= mode;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == 5'd0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            result <= step;
            cnt    <= cnt - 5'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: randomized and directed checks of seq_shifter
// against an arithmetic model of the shift result and timing.
module tb_seq_shifter;

  logic        clock;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [31:0] din;
  logic [4:0]  shamt;
  logic [1:0]  mode;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int vecs;
  int errs;

  seq_shifter dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .abort  (abort),
    .din    (din),
    .shamt  (shamt),
    .mode   (mode),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] model(input logic [31:0] d,
                                        input int n,
                                        input logic [1:0] m);
    logic [63:0] t;
    logic [31:0] r;
    t = {d, d} >> n;
    case (m)
      2'b00:   r = d << n;
      2'b01:   r = d >> n;
      2'b10:   r = $unsigned($signed(d) >>> n);
      default: r = t[31:0];
    endcase
    return r;
  endfunction

  // caller is between edges; start is accepted at the next rising edge
  task automatic launch(input logic [31:0] d, input logic [4:0] n,
                        input logic [1:0] m);
    din   = d;
    shamt = n;
    mode  = m;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    din   = $urandom;
    shamt = 5'($urandom);
    mode  = 2'($urandom);
  endtask

  // waits for done, checking busy each cycle, latency and final result
  task automatic finish_op(input string tag, input logic [31:0] d,
                           input logic [4:0] n, input logic [1:0] m,
                           input bit poke, input bit after);
    logic [31:0] exp;
    int got;
    exp = model(d, int'(n), m);
    got = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (poke && k == 1) begin
        start = 1'b1;
        din   = 32'hFFFF_FFFF;
        shamt = 5'd0;
      end
      if (poke && k == 2) start = 1'b0;
      if (done) begin
        got = k;
        break;
      end
      vecs++;
      if (busy !== 1'b1) begin
        errs++;
        $display("FAIL %s busy cyc%0d got %b want 1", tag, k, busy);
      end
    end
    vecs++;
    if (got != int'(n) + 1) begin
      errs++;
      $display("FAIL %s latency got %0d want %0d", tag, got, int'(n) + 1);
    end
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL %s busy_at_done got %b want 0", tag, busy);
    end
    vecs++;
    if (result !== exp) begin
      errs++;
      $display("FAIL %s result got %h want %h", tag, result, exp);
    end
    if (after) begin
      @(posedge clock);
      #1;
      vecs++;
      if (done !== 1'b0) begin
        errs++;
        $display("FAIL %s done_pulse got %b want 0", tag, done);
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] d,
                        input logic [4:0] n, input logic [1:0] m);
    @(negedge clock);
    launch(d, n, m);
    finish_op(tag, d, n, m, 1'b0, 1'b1);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    din    = '0;
    shamt  = '0;
    mode   = '0;
    repeat (2) @(posedge clock);
    #1;
    vecs++;
    if ({result, busy, done} !== 34'd0) begin
      errs++;
      $display("FAIL reset_init got %h/%b/%b want 0/0/0",
               result, busy, done);
    end
    @(negedge clock);
    resetn = 1'b1;
    launch(32'hDEAD_BEEF, 5'd10, 2'b00);
    vecs++;
    if (result !== 32'hDEAD_BEEF || busy !== 1'b1) begin
      errs++;
      $display("FAIL reset_load got %h/%b want deadbeef/1", result, busy);
    end
    #1;
    resetn = 1'b0;
    #1;
    vecs++;
    if ({result, busy, done} !== 34'd0) begin
      errs++;
      $display("FAIL reset_async got %h/%b/%b want 0/0/0",
               result, busy, done);
    end
    @(negedge clock);
    resetn = 1'b1;
    run_op("reset_after", 32'h1234_0001, 5'd3, 2'b00);
  endtask

  task automatic test_sra_srl;
    run_op("sra", 32'h8000_0000, 5'd4, 2'b10);
    vecs++;
    if (result !== 32'hF800_0000) begin
      errs++;
      $display("FAIL sra_const got %h want f8000000", result);
    end
    run_op("srl", 32'h8000_0000, 5'd4, 2'b01);
    vecs++;
    if (result !== 32'h0800_0000) begin
      errs++;
      $display("FAIL srl_const got %h want 08000000", result);
    end
  endtask

  task automatic test_sll_max;
    run_op("sll31", 32'h0000_0001, 5'd31, 2'b00);
    vecs++;
    if (result !== 32'h8000_0000) begin
      errs++;
      $display("FAIL sll31_const got %h want 80000000", result);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clock);
    launch(32'h1234_5678, 5'd8, 2'b11);
    finish_op("ror", 32'h1234_5678, 5'd8, 2'b11, 1'b0, 1'b0);
    vecs++;
    if (result !== 32'h7812_3456) begin
      errs++;
      $display("FAIL ror_const got %h want 78123456", result);
    end
    launch(32'h0000_0001, 5'd0, 2'b00);
    finish_op("b2b", 32'h0000_0001, 5'd0, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic test_ignore_abort;
    @(negedge clock);
    launch(32'h0F0F_1234, 5'd6, 2'b01);
    finish_op("ign_start", 32'h0F0F_1234, 5'd6, 2'b01, 1'b1, 1'b1);
    @(negedge clock);
    launch(32'h0000_0001, 5'd10, 2'b00);
    @(posedge clock);
    #1;
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0000_0002) begin
      errs++;
      $display("FAIL abort got %h/%b/%b want 00000002/0/0",
               result, busy, done);
    end
    for (int k = 0; k < 12; k++) begin
      @(posedge clock);
      #1;
      if (k == 3) abort = 1'b1;
      if (k == 5) abort = 1'b0;
      vecs++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== 32'h0000_0002) begin
        errs++;
        $display("FAIL abort_idle cyc%0d got %h/%b/%b want 00000002/0/0",
                 k, result, busy, done);
      end
    end
  endtask

  task automatic test_zero_shift;
    for (int m = 0; m < 4; m++)
      run_op("zero", 32'hA5A5_A5A5, 5'd0, 2'(m));
  endtask

  task automatic test_random;
    logic [31:0] d;
    logic [4:0]  n;
    logic [1:0]  m;
    for (int i = 0; i < 40; i++) begin
      d = $urandom;
      n = 5'($urandom);
      m = 2'($urandom);
      run_op("rand", d, n, m);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_sra_srl();
    test_sll_max();
    test_back_to_back();
    test_ignore_abort();
    test_zero_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
